// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit. The carry ripples one SW-bit slice per stage, with valid/ready on both sides.
// Optional macro PIPELINED_ADDER_OVF_EN adds the registered signed-overflow output ovf.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage state: operands (B pre-inverted for subtract), partial sum, slice carry, valid.
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;

  // Stage inputs: stage 0 from the ports, stage k from the registers of stage k-1.
  logic [STAGES-1:0]            in_v;
  logic [STAGES-1:0]            in_c;
  logic [STAGES-1:0][WIDTH-1:0] in_a;
  logic [STAGES-1:0][WIDTH-1:0] in_b;
  logic [STAGES-1:0][WIDTH-1:0] in_s;
  logic [SW:0]                  slice;
  logic                         stall_c;

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    stall_c  = valid_q[LAST] & ~out_ready;
    in_ready = ~stall_c;

    valid_d = valid_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    slice   = '0;
`ifdef PIPELINED_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    in_v    = '0;
    in_c    = '0;
    in_a    = '0;
    in_b    = '0;
    in_s    = '0;
    in_v[0] = in_valid;
    in_c[0] = sub | cin;
    in_a[0] = A;
    in_b[0] = sub ? ~B : B;
    for (int k = 1; k < STAGES; k++) begin
      in_v[k] = valid_q[k-1];
      in_c[k] = c_q[k-1];
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_s[k] = s_q[k-1];
    end

    // Rigid shift: every stage advances together unless the output is blocked.
    if (!stall_c) begin
      for (int k = 0; k < STAGES; k++) begin
        slice = {1'b0, in_a[k][k*SW +: SW]} + {1'b0, in_b[k][k*SW +: SW]}
              + (SW+1)'(in_c[k]);
        valid_d[k]           = in_v[k];
        a_d[k]               = in_a[k];
        b_d[k]               = in_b[k];
        s_d[k]               = in_s[k];
        s_d[k][k*SW +: SW]   = slice[SW-1:0];
        c_d[k]               = slice[SW];
      end
`ifdef PIPELINED_ADDER_OVF_EN
      // Carry into the MSB recovered from the MSB operand bits and result bit.
      ovf_d = in_a[LAST][WIDTH-1] ^ in_b[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_valid = valid_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: a 16-bit/4-stage instance and a 1-bit/1-stage instance.
// Overflow checks compile in when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [15:0] A, B, sum;
  logic        in_valid1, in_ready1, a1, b1, cin1, sub1, out_valid1, out_ready1, sum1, cout1;
`ifdef PIPELINED_ADDER_OVF_EN
  logic        ovf, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .A(a1), .B(b1),
    .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, cout, sum} !== 18'h0) begin
      errors++; $display("FAIL reset16 got v=%b c=%b s=%h want 0/0/0000", out_valid, cout, sum);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if ({out_valid1, cout1, sum1} !== 3'b000) begin
      errors++; $display("FAIL reset1 got v=%b c=%b s=%b want 000", out_valid1, cout1, sum1);
    end
  endtask

  task automatic test_full_adder();
    logic [1:0] exp_fa [8];
    logic [2:0] bits;
    exp_fa = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    for (int i = 0; i < 8; i++) begin
      bits = 3'(i);
      a1 = bits[2]; b1 = bits[1]; cin1 = bits[0]; in_valid1 = 1'b1;
      step();
      checks++;
      if (out_valid1 !== 1'b1 || {cout1, sum1} !== exp_fa[i]) begin
        errors++;
        $display("FAIL fa_%0d got v=%b {c,s}=%0d want v=1 {c,s}=%0d", i, out_valid1, {cout1, sum1}, exp_fa[i]);
      end
    end
    in_valid1 = 1'b0;
    step();
    checks++;
    if (out_valid1 !== 1'b0) begin errors++; $display("FAIL fa_drain got v=%b want 0", out_valid1); end
  endtask

  task automatic test_streaming();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [15:0] es [3];
    logic        ec [3];
    va = '{16'hFFFF, 16'h1234, 16'h8000};
    vb = '{16'h0001, 16'h4321, 16'h8000};
    vc = '{1'b0, 1'b1, 1'b0};
    es = '{16'h0000, 16'h5556, 16'h0000};
    ec = '{1'b1, 1'b0, 1'b1};
    out_ready = 1'b1; sub = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; A = va[c]; B = vb[c]; cin = vc[c];
      end else begin
        in_valid = 1'b0;
      end
      step();
      checks++;
      if (c >= 3 && c < 6) begin
        if (out_valid !== 1'b1 || sum !== es[c-3] || cout !== ec[c-3]) begin
          errors++;
          $display("FAIL stream_%0d got v=%b s=%h c=%b want v=1 s=%h c=%b", c - 3, out_valid, sum, cout, es[c-3], ec[c-3]);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stream_idle_%0d got v=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_subtract();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vc [4];
    logic [15:0] es [4];
    logic        ec [4];
    va = '{16'h0005, 16'h0005, 16'h0003, 16'h0003};
    vb = '{16'h0003, 16'h0003, 16'h0005, 16'h0005};
    vc = '{1'b0, 1'b1, 1'b0, 1'b1};
    es = '{16'h0002, 16'h0002, 16'hFFFE, 16'hFFFE};
    ec = '{1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; sub = 1'b1; A = va[c]; B = vb[c]; cin = vc[c];
      end else begin
        in_valid = 1'b0; sub = 1'b0; cin = 1'b0;
      end
      step();
      if (c >= 3 && c < 7) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== es[c-3] || cout !== ec[c-3]) begin
          errors++;
          $display("FAIL sub_%0d got v=%b s=%h c=%b want v=1 s=%h c=%b", c - 3, out_valid, sum, cout, es[c-3], ec[c-3]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] es [4];
    logic        ec [4];
    logic [15:0] held_s;
    logic        held_c, held, acc;
    int          idx, got, stalls;
    va = '{16'h0001, 16'h0010, 16'h0100, 16'hF000};
    vb = '{16'h0001, 16'h0020, 16'h0200, 16'h1000};
    es = '{16'h0002, 16'h0030, 16'h0300, 16'h0000};
    ec = '{1'b0, 1'b0, 1'b0, 1'b1};
    idx = 0; got = 0; stalls = 0; held = 1'b0; held_s = '0; held_c = 1'b0;
    sub = 1'b0; cin = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (idx < 4);
      if (idx < 4) begin A = va[idx]; B = vb[idx]; end
      #1;
      if (out_valid === 1'b1 && out_ready == 1'b0) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", cyc, in_ready); end
        if (held) begin
          checks++;
          if (sum !== held_s || cout !== held_c) begin
            errors++; $display("FAIL bp_hold cyc%0d got s=%h c=%b want s=%h c=%b", cyc, sum, cout, held_s, held_c);
          end
        end
        held = 1'b1; held_s = sum; held_c = cout;
      end else if (out_valid === 1'b1) begin
        held = 1'b0;
        checks++;
        if (sum !== es[got] || cout !== ec[got]) begin
          errors++; $display("FAIL bp_order_%0d got s=%h c=%b want s=%h c=%b", got, sum, cout, es[got], ec[got]);
        end
        got++;
      end
      acc = in_valid & in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got !== 4 || stalls !== 3) begin
      errors++; $display("FAIL bp_count got beats=%0d stalls=%0d want beats=4 stalls=3", got, stalls);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup cyc%0d got v=%b want 0", c, out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; A = 16'(16'h1111 * (c + 1)); B = 16'h0101;
      rst = (c == 2);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, cout, sum} !== 18'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got v=%b c=%b s=%h rdy=%b want 0/0/0000 rdy=1", out_valid, cout, sum, in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale cyc%0d got v=%b want 0", c, out_valid); end
    end
    in_valid = 1'b1; A = 16'h0102; B = 16'h0304;
    for (int c = 1; c <= 4; c++) begin
      step();
      in_valid = 1'b0;
      checks++;
      if (c < 4 && out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_lat_early edge%0d got v=%b want 0", c, out_valid);
      end else if (c == 4 && (out_valid !== 1'b1 || sum !== 16'h0406 || cout !== 1'b0)) begin
        errors++; $display("FAIL rst_lat got v=%b s=%h c=%b want v=1 s=0406 c=0", out_valid, sum, cout);
      end
    end
    step();
  endtask

`ifdef PIPELINED_ADDER_OVF_EN
  task automatic test_ovf();
    logic [15:0] va [3];
    logic [15:0] es [3];
    logic        ec [3];
    logic        eo [3];
    va = '{16'h7FFF, 16'h8000, 16'h0001};
    es = '{16'h8000, 16'h0000, 16'h0002};
    ec = '{1'b0, 1'b1, 1'b0};
    eo = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; A = va[c];
        B = (c == 1) ? 16'h8000 : 16'h0001;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== es[c-3] || cout !== ec[c-3] || ovf !== eo[c-3]) begin
          errors++;
          $display("FAIL ovf_%0d got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b", c - 3, out_valid, sum, cout, ovf, es[c-3], ec[c-3], eo[c-3]);
        end
      end
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_full_adder();
    test_streaming();
    test_subtract();
    test_backpressure();
    test_reset_mid();
`ifdef PIPELINED_ADDER_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
